ex_hazard_ctrl: RTL
===================

# ex_hazard_ctrl

Pipeline controller for the 16-bit five-stage core that sequences the execute stage. It generates the registered forwarding selects that steer execute's operand muxes, and it detects load-use hazards and inserts one bubble. It also squashes wrong-path instructions when a branch or jump is taken, and drains the pipe on HALT. It sits beside the ID/EX pipeline register and drives the write enables of the PC, IF/ID and ID/EX registers.

## Interface
- No parameters. Register specifiers are 3 bits (8 GPRs, r0 is an ordinary register). Data width is irrelevant to this block.
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- id_rs, id_rt  in  3 each  source registers of the instruction in ID
- id_rs_vld, id_rt_vld  in  1 each  corresponding source is actually read
- id_halt  in  1  ID holds HALT
- idex_rd, idex_regwr, idex_memrd  in  3/1/1  destination, write enable and load flag of the instruction in EX
- exmem_rd, exmem_regwr  in  3/1  destination and write enable of the instruction in MEM
- ex_redirect  in  1  branch taken, or J/JR/JAL/JALR, resolved in EX this cycle
- forwardA, forwardB  out  2 each  registered operand selects for EX: 00 register file, 01 MEM/WB data, 10 EX/MEM ALU result, 11 never driven
- pc_we, ifid_we  out  1 each  PC and IF/ID load enables
- idex_bubble  out  1  load NOP (all control zero) into ID/EX
- ifid_flush  out  1  load NOP into IF/ID
- halted  out  1  pipeline fully drained after HALT

## Operation
- FSM states: RUN, STALL, DRAIN, HALTED. Reset state is RUN.
- Forward compute runs in ID and is registered into forwardA/forwardB on the clock edge that advances ID→EX. It applies per source and only if that source's valid bit is set.
  - If the source equals idex_rd and idex_regwr=1 and idex_memrd=0, the select is 10.
  - Otherwise, if the source equals exmem_rd and exmem_regwr=1, the select is 01.
  - Otherwise the select is 00.
  - The idex match has priority, because it is the younger producer.
- Load-use: idex_memrd=1, idex_regwr=1, and idex_rd matches a valid ID source.
  - pc_we=0, ifid_we=0 and idex_bubble=1 for one cycle. State goes RUN→STALL.
  - In STALL the same instruction is re-evaluated. The producer is now in MEM, so the select is 01. State returns to RUN, and the stall never exceeds one cycle.
- Redirect: ex_redirect=1 has priority over load-use and over halt.
  - ifid_flush=1 and idex_bubble=1 for that cycle. pc_we=1 so the PC takes the EX target.
  - STALL is aborted to RUN.
  - The forward registers load 00 when a bubble enters ID/EX.
- Halt: id_halt=1 in RUN with no redirect.
  - pc_we=0 and ifid_we=0 from then on. HALT proceeds down the pipe.
  - A 2-bit counter is loaded with 3 and the state goes to DRAIN.
  - In DRAIN, idex_bubble=1 each cycle and the counter decrements. At 0 the state goes to HALTED.
  - A redirect in DRAIN returns the state to RUN (HALT was wrong-path).
  - HALTED is sticky until rst. halted=1, pc_we=0, ifid_we=0, idex_bubble=1.

## Timing
- Reset values: forwardA=forwardB=00, pc_we=1, ifid_we=1, idex_bubble=0, ifid_flush=0, halted=0, counter=0.
- pc_we, ifid_we, idex_bubble and ifid_flush are combinational from the current state and inputs, valid in the same cycle.
- forwardA and forwardB have 1-cycle latency. They change only on edges where ID/EX loads, and are held while stalled.
- Simultaneous load-use and redirect: the redirect wins and no stall is taken.
- Simultaneous id_halt and load-use: the stall is taken first, and HALT is recognised in the following RUN cycle.
- rst asserted mid-stall or mid-drain returns all outputs to reset values immediately, without waiting for a clock.

## Structure
- A shared package holds:
  - the state encodings (2-bit, localparam RUN=0, STALL=1, DRAIN=2, HALTED=3);
  - the forward codes FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10;
  - DRAIN_CYCLES=3.
- One sub-module, fwd_sel, is combinational: it computes one 2-bit select from (src, src_vld, idex_*, exmem_*). It is instantiated twice, for rs and rt.
- The FSM, counter and forward registers live in the top module. The forward registers are built from the codebase's dff cells.

## Test plan
- id_rs=3, valid, idex_rd=3, idex_regwr=1, idex_memrd=0 -> forwardA=10 after the next edge. With only exmem_rd=3 instead -> 01. With both matching -> 10.
- idex_memrd=1, idex_rd=5, id_rt=5 valid -> one cycle of pc_we=0, ifid_we=0, idex_bubble=1, then forwardB=01 and RUN.
- Load-use and ex_redirect=1 in the same cycle -> no stall, ifid_flush=1, idex_bubble=1, pc_we=1, forward registers 00.
- id_halt=1 -> three cycles of idex_bubble=1 in DRAIN, then halted=1, held for 10+ cycles until rst=0.
- rst=0 asserted during STALL, between clock edges -> outputs reach reset values immediately. Release rst -> RUN, pc_we=1.
- id_rs_vld=0 with id_rs matching idex_rd -> forwardA=00 and no stall.

Source files
------------

// File: rtl/ex_hazard_ctrl_pkg.sv
// ex_hazard_ctrl_pkg
// Shared encodings for the execute-stage hazard controller: FSM states,
// operand-forward select codes and the HALT drain length.
package ex_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [1:0] DRAIN_CYCLES = 2'd3;

endpackage

// File: rtl/dff.sv
// dff
// Generic enabled D flip-flop with asynchronous active-low reset to zero.
// Ports: clk_i, rst_ni, en_i (load enable), d_i, q_o (W bits each).
module dff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   q_o <= '0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/ex_hazard_ctrl_fwd_sel.sv
// fwd_sel
// Combinational operand-forward select for one ID source register.
// Ports: src_i/src_vld_i (ID source and its read flag), idex_rd_i/
// idex_regwr_i/idex_memrd_i (producer in EX), exmem_rd_i/exmem_regwr_i
// (producer in MEM), sel_o (FWD_RF / FWD_MEMWB / FWD_EXMEM).
module fwd_sel
  import ex_hazard_ctrl_pkg::*;
(
  input  logic [2:0] src_i,
  input  logic       src_vld_i,
  input  logic [2:0] idex_rd_i,
  input  logic       idex_regwr_i,
  input  logic       idex_memrd_i,
  input  logic [2:0] exmem_rd_i,
  input  logic       exmem_regwr_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (src_vld_i) begin
      // EX producer is younger so it wins; a load in EX has no ALU result yet.
      if (src_i == idex_rd_i && idex_regwr_i && !idex_memrd_i)
        sel_o = FWD_EXMEM;
      else if (src_i == exmem_rd_i && exmem_regwr_i)
        sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
// Execute-stage pipeline controller: registered operand-forward selects,
// one-cycle load-use stall, wrong-path squash on redirect, HALT drain.
// Inputs : clk, rst (async, active-low), id_rs/id_rt + valids, id_halt,
//          idex_rd/idex_regwr/idex_memrd, exmem_rd/exmem_regwr, ex_redirect.
// Outputs: forwardA/forwardB (registered), pc_we, ifid_we, idex_bubble,
//          ifid_flush (combinational), halted.
//
// state  | meaning
// RUN    | normal issue; checks redirect, load-use, HALT in that order
// STALL  | load-use bubble inserted last cycle; ID re-evaluated and advanced
// DRAIN  | HALT moving down the pipe; bubbles inserted while counter runs
// HALTED | pipe drained; frozen until reset
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] id_rs,
  input  logic [2:0] id_rt,
  input  logic       id_rs_vld,
  input  logic       id_rt_vld,
  input  logic       id_halt,
  input  logic [2:0] idex_rd,
  input  logic       idex_regwr,
  input  logic       idex_memrd,
  input  logic [2:0] exmem_rd,
  input  logic       exmem_regwr,
  input  logic       ex_redirect,
  output logic [1:0] forwardA,
  output logic [1:0] forwardB,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       idex_bubble,
  output logic       ifid_flush,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] fwd_a_c, fwd_b_c, fwd_a_d, fwd_b_d;
  logic       load_use, stall_now, fwd_en;
  logic       pc_c, ifid_c, bub_c, flush_c;

  fwd_sel u_fwd_a (
    .src_i(id_rs), .src_vld_i(id_rs_vld),
    .idex_rd_i(idex_rd), .idex_regwr_i(idex_regwr), .idex_memrd_i(idex_memrd),
    .exmem_rd_i(exmem_rd), .exmem_regwr_i(exmem_regwr), .sel_o(fwd_a_c)
  );

  fwd_sel u_fwd_b (
    .src_i(id_rt), .src_vld_i(id_rt_vld),
    .idex_rd_i(idex_rd), .idex_regwr_i(idex_regwr), .idex_memrd_i(idex_memrd),
    .exmem_rd_i(exmem_rd), .exmem_regwr_i(exmem_regwr), .sel_o(fwd_b_c)
  );

  assign load_use = idex_memrd && idex_regwr &&
                    ((id_rs_vld && id_rs == idex_rd) ||
                     (id_rt_vld && id_rt == idex_rd));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_c      = 1'b1;
    ifid_c    = 1'b1;
    bub_c     = 1'b0;
    flush_c   = 1'b0;
    stall_now = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          flush_c = 1'b1;
          bub_c   = 1'b1;
        end else if (load_use) begin
          pc_c      = 1'b0;
          ifid_c    = 1'b0;
          bub_c     = 1'b1;
          stall_now = 1'b1;
          state_d   = STALL;
        end else if (id_halt) begin
          pc_c    = 1'b0;
          ifid_c  = 1'b0;
          cnt_d   = DRAIN_CYCLES;
          state_d = DRAIN;
        end
      end
      STALL: begin
        // Never stall twice: the producer has moved to MEM by now.
        state_d = RUN;
        if (ex_redirect) begin
          flush_c = 1'b1;
          bub_c   = 1'b1;
        end
      end
      DRAIN: begin
        if (ex_redirect) begin
          flush_c = 1'b1;
          bub_c   = 1'b1;
          cnt_d   = 2'd0;
          state_d = RUN;
        end else begin
          pc_c   = 1'b0;
          ifid_c = 1'b0;
          bub_c  = 1'b1;
          cnt_d  = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = HALTED;
        end
      end
      HALTED: begin
        pc_c   = 1'b0;
        ifid_c = 1'b0;
        bub_c  = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Combinational outputs are forced to reset values while rst is low so
  // the pipe sees a clean state without waiting for a clock.
  assign pc_we       = rst ? pc_c    : 1'b1;
  assign ifid_we     = rst ? ifid_c  : 1'b1;
  assign idex_bubble = rst ? bub_c   : 1'b0;
  assign ifid_flush  = rst ? flush_c : 1'b0;
  assign halted      = (state_q == HALTED);

  // ID/EX holds during a load-use stall; a bubble entering it clears the selects.
  assign fwd_en  = !stall_now;
  assign fwd_a_d = bub_c ? FWD_RF : fwd_a_c;
  assign fwd_b_d = bub_c ? FWD_RF : fwd_b_c;

  dff #(.W(2)) u_fwd_a_q (
    .clk_i(clk), .rst_ni(rst), .en_i(fwd_en), .d_i(fwd_a_d), .q_o(forwardA)
  );

  dff #(.W(2)) u_fwd_b_q (
    .clk_i(clk), .rst_ni(rst), .en_i(fwd_en), .d_i(fwd_b_d), .q_o(forwardB)
  );

endmodule
